mod10_cmd_conditioner: RTL and testbench

//   Upstream stage of the mod-10 counter path. Synchronises and debounces raw board buttons and switches.

---
 rtl/mod10_pkg.sv | 31 +++
 rtl/debounce_sync.sv | 57 +++++
 rtl/mod10_cmd_conditioner.sv | 150 +++++++++++++++
 tb/tb_mod10_cmd_conditioner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mod10_pkg.sv
// -----------------------------------------------------------------------------
// mod10_pkg
//   Encodings shared by the mod-10 counter path: the 3-bit ctrl command word
//   understood by mod10_counter and the command-conditioner FSM states.
//   A helper maps a steady (non-command) state onto its ctrl code.
// -----------------------------------------------------------------------------
package mod10_pkg;

    localparam logic [2:0] CTRL_HOLD  = 3'b000;
    localparam logic [2:0] CTRL_UP    = 3'b001;
    localparam logic [2:0] CTRL_DOWN  = 3'b010;
    localparam logic [2:0] CTRL_LOAD  = 3'b011;
    localparam logic [2:0] CTRL_CLEAR = 3'b100;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_UP   = 2'd1,
        S_DN   = 2'd2,
        S_CMD  = 2'd3
    } state_t;

    // ctrl code of a steady state; S_CMD carries its own recorded code.
    function automatic logic [2:0] state_ctrl(input state_t s);
        case (s)
            S_UP:    return CTRL_UP;
            S_DN:    return CTRL_DOWN;
            default: return CTRL_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//   One raw board input: 2-flop synchroniser, debouncer and rising-edge strobe.
//   The debounced level only follows the synchronised input after it has
//   disagreed with the current level for DB_CYCLES consecutive cycles.
// Ports
//   clk    in  1  system clock
//   rst    in  1  asynchronous reset, active high
//   din    in  1  raw asynchronous input
//   level  out 1  debounced level
//   rise   out 1  one-cycle strobe, high the cycle level goes 0->1
// -----------------------------------------------------------------------------
module debounce_sync #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic          level_reg;
    logic          rise_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg  <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync_reg <= {sync_reg[0], din};
            rise_reg <= 1'b0;
            if (sync_reg[1] == level_reg) begin
                // Any agreeing cycle restarts the stability window.
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Clears at terminal, so the counter never wraps.
                cnt_reg   <= '0;
                level_reg <= sync_reg[1];
                rise_reg  <= sync_reg[1];
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/mod10_cmd_conditioner.sv
// -----------------------------------------------------------------------------
// mod10_cmd_conditioner
//   Conditions raw buttons/switches into the ctrl/inp command pair consumed by
//   mod10_counter. UP/DN presses toggle between counting and pause; LOAD and
//   CLEAR are stretched to CMD_HOLD cycles so the slow counter clock sees them.
// Ports
//   sys_clk  in  1  system clock, rising edge
//   rst_n    in  1  asynchronous reset, active HIGH (1 = reset)
//   btn_up   in  1  raw button: count up / pause
//   btn_dn   in  1  raw button: count down / pause
//   btn_ld   in  1  raw button: load switch value
//   btn_clr  in  1  raw button: clear counter
//   sw       in  4  raw switches: load value
//   ctrl     out 3  command word (see mod10_pkg CTRL_*)
//   inp      out 4  load value, captured on LOAD entry only
//   busy     out 1  high while a LOAD/CLEAR is being held
// -----------------------------------------------------------------------------
module mod10_cmd_conditioner
    import mod10_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000,
    parameter int CMD_HOLD  = 100_000_000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_ld,
    input  logic       btn_clr,
    input  logic [3:0] sw,
    output logic [2:0] ctrl,
    output logic [3:0] inp,
    output logic       busy
);

    localparam int HW = (CMD_HOLD > 1) ? $clog2(CMD_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(CMD_HOLD - 1);

    // Bits 0..3: up, dn, ld, clr buttons; bits 4..7: switches.
    logic [7:0] raw_in;
    logic [7:0] db_level;
    logic [7:0] db_rise;

    assign raw_in = {sw, btn_clr, btn_ld, btn_dn, btn_up};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_db
            debounce_sync #(
                .DB_CYCLES(DB_CYCLES)
            ) u_db (
                .clk   (sys_clk),
                .rst   (rst_n),
                .din   (raw_in[gi]),
                .level (db_level[gi]),
                .rise  (db_rise[gi])
            );
        end
    endgenerate

    // Buttons only matter as presses, switches only as levels.
    logic unused_db;
    assign unused_db = ^{db_level[3:0], db_rise[7:4]};

    logic       press_up, press_dn, press_ld, press_clr;
    logic [3:0] sw_db;

    assign press_up  = db_rise[0];
    assign press_dn  = db_rise[1];
    assign press_ld  = db_rise[2];
    assign press_clr = db_rise[3];
    assign sw_db     = db_level[7:4];

    state_t          state_reg, state_next;
    state_t          ret_reg, ret_next;
    logic [2:0]      code_reg, code_next;
    logic [2:0]      ctrl_reg, ctrl_next;
    logic [3:0]      inp_reg, inp_next;
    logic            busy_reg, busy_next;
    logic [HW-1:0]   hold_reg, hold_next;

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg <= S_HOLD;
            ret_reg   <= S_HOLD;
            code_reg  <= CTRL_HOLD;
            ctrl_reg  <= CTRL_HOLD;
            inp_reg   <= '0;
            busy_reg  <= 1'b0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ret_reg   <= ret_next;
            code_reg  <= code_next;
            ctrl_reg  <= ctrl_next;
            inp_reg   <= inp_next;
            busy_reg  <= busy_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ret_next   = ret_reg;
        code_next  = code_reg;
        inp_next   = inp_reg;
        busy_next  = busy_reg;
        hold_next  = hold_reg;

        case (state_reg)
            S_CMD: begin
                // Presses are ignored here; simply run out the hold window.
                if (hold_reg == HOLD_LAST) begin
                    state_next = ret_reg;
                    busy_next  = 1'b0;
                    hold_next  = '0;
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            default: begin
                // Priority clr > ld > dn > up; losers this cycle are dropped.
                if (press_clr) begin
                    state_next = S_CMD;
                    ret_next   = state_reg;
                    code_next  = CTRL_CLEAR;
                    busy_next  = 1'b1;
                    hold_next  = '0;
                end else if (press_ld) begin
                    state_next = S_CMD;
                    ret_next   = state_reg;
                    code_next  = CTRL_LOAD;
                    inp_next   = sw_db;
                    busy_next  = 1'b1;
                    hold_next  = '0;
                end else if (press_dn) begin
                    state_next = (state_reg == S_DN) ? S_HOLD : S_DN;
                end else if (press_up) begin
                    state_next = (state_reg == S_UP) ? S_HOLD : S_UP;
                end
            end
        endcase

        ctrl_next = (state_next == S_CMD) ? code_next : state_ctrl(state_next);
    end

    assign ctrl = ctrl_reg;
    assign inp  = inp_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_mod10_cmd_conditioner.sv
// -----------------------------------------------------------------------------
// tb_mod10_cmd_conditioner
//   Scoreboard bench: each stimulus step queues the {busy,inp,ctrl} words
//   expected at given cycles; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_mod10_cmd_conditioner;
    import mod10_pkg::*;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       btn_up  = 1'b0;
    logic       btn_dn  = 1'b0;
    logic       btn_ld  = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] sw      = 4'b0000;
    logic [2:0] ctrl;
    logic [3:0] inp;
    logic       busy;

    mod10_cmd_conditioner #(
        .DB_CYCLES(4),
        .CMD_HOLD (8)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .btn_ld  (btn_ld),
        .btn_clr (btn_clr),
        .sw      (sw),
        .ctrl    (ctrl),
        .inp     (inp),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         cyc;
        logic [7:0] word;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] w(input logic b, input logic [3:0] i, input logic [2:0] c);
        return {b, i, c};
    endfunction

    task automatic expect_at(input int c, input logic [7:0] word, input string tag);
        exp_t e;
        e.cyc  = c;
        e.word = word;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge sys_clk) begin : mon
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc < cyc)
                check({e.tag, "_late"}, cyc, e.cyc);
            else
                check(e.tag, {busy, inp, ctrl}, e.word);
            $display("[cyc %0d] %s: ctrl=%b inp=%b busy=%b (exp ctrl=%b inp=%b busy=%b)",
                     cyc, e.tag, ctrl, inp, busy, e.word[2:0], e.word[6:3], e.word[7]);
        end
    end

    // Button press: old word still present 6 cycles after the raw edge,
    // new word appears at 2 sync + 4 debounce + 1 register = 7 cycles.
    task automatic press(input logic [3:0] btns, input logic [7:0] old_w,
                         input logic [7:0] new_w, input string tag);
        int e;
        e = cyc;
        expect_at(e + 6, old_w, {tag, "_pre"});
        expect_at(e + 7, new_w, tag);
        {btn_clr, btn_ld, btn_dn, btn_up} = btns;
        tick(10);
        {btn_clr, btn_ld, btn_dn, btn_up} = 4'b0000;
        tick(10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e;

        // Async reset takes effect before any clock edge.
        #1 rst_n = 1'b1;
        #1;
        check("rst_async_ctrl", ctrl, CTRL_HOLD);
        check("rst_async_inp",  inp,  4'd0);
        check("rst_async_busy", busy, 1'b0);
        tick(3);
        rst_n = 1'b0;
        tick(3);

        // Bounce: 2-cycle toggles for 20 cycles, then steady high.
        e = cyc;
        expect_at(e + 10, w(0, 4'd0, CTRL_HOLD), "bounce_mid");
        expect_at(e + 20, w(0, 4'd0, CTRL_HOLD), "bounce_end");
        for (int i = 0; i < 10; i++) begin
            btn_up = ~btn_up;
            tick(2);
        end
        press(4'b0001, w(0, 4'd0, CTRL_HOLD), w(0, 4'd0, CTRL_UP), "bounce_up");

        // Pause / direction.
        press(4'b0001, w(0, 4'd0, CTRL_UP),   w(0, 4'd0, CTRL_HOLD), "pause_up");
        press(4'b0010, w(0, 4'd0, CTRL_HOLD), w(0, 4'd0, CTRL_DOWN), "hold_dn");
        press(4'b0001, w(0, 4'd0, CTRL_DOWN), w(0, 4'd0, CTRL_UP),   "dn_up");
        press(4'b0010, w(0, 4'd0, CTRL_UP),   w(0, 4'd0, CTRL_DOWN), "up_dn");

        // Load from S_DN; sw change during the hold must not reach inp.
        sw = 4'b0111;
        tick(10);
        e = cyc;
        expect_at(e + 6,  w(0, 4'd0, CTRL_DOWN), "load_pre");
        expect_at(e + 7,  w(1, 4'd7, CTRL_LOAD), "load_start");
        expect_at(e + 11, w(1, 4'd7, CTRL_LOAD), "load_mid");
        expect_at(e + 14, w(1, 4'd7, CTRL_LOAD), "load_last");
        expect_at(e + 15, w(0, 4'd7, CTRL_DOWN), "load_exit");
        expect_at(e + 30, w(0, 4'd7, CTRL_DOWN), "load_sw_isolated");
        btn_ld = 1'b1;
        tick(8);
        sw = 4'b1111;
        tick(8);
        btn_ld = 1'b0;
        tick(20);

        // Simultaneous clr+ld: clear wins, ld dropped, inp untouched.
        e = cyc;
        expect_at(e + 6,  w(0, 4'd7, CTRL_DOWN),  "clr_ld_pre");
        expect_at(e + 7,  w(1, 4'd7, CTRL_CLEAR), "clr_ld_start");
        expect_at(e + 14, w(1, 4'd7, CTRL_CLEAR), "clr_ld_last");
        expect_at(e + 15, w(0, 4'd7, CTRL_DOWN),  "clr_ld_exit");
        expect_at(e + 25, w(0, 4'd7, CTRL_DOWN),  "clr_ld_after");
        btn_clr = 1'b1;
        btn_ld  = 1'b1;
        tick(20);
        btn_clr = 1'b0;
        btn_ld  = 1'b0;
        tick(20);

        // 3-cycle glitch on btn_clr is shorter than the debounce window.
        e = cyc;
        expect_at(e + 8,  w(0, 4'd7, CTRL_DOWN), "glitch_a");
        expect_at(e + 14, w(0, 4'd7, CTRL_DOWN), "glitch_b");
        btn_clr = 1'b1;
        tick(3);
        btn_clr = 1'b0;
        tick(16);

        // Reset mid-hold aborts immediately, without a clock edge.
        sw = 4'b0011;
        tick(10);
        e = cyc;
        expect_at(e + 7, w(1, 4'd3, CTRL_LOAD), "load2_start");
        btn_ld = 1'b1;
        tick(10);
        #1 rst_n = 1'b1;
        #1;
        check("rst_mid_ctrl", ctrl, CTRL_HOLD);
        check("rst_mid_inp",  inp,  4'd0);
        check("rst_mid_busy", busy, 1'b0);
        btn_ld = 1'b0;
        tick(2);
        rst_n = 1'b0;
        e = cyc;
        expect_at(e + 12, w(0, 4'd0, CTRL_HOLD), "post_rst_idle");
        tick(16);

        check("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
